// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the A09 run monitor: FSM states, dump tags, counter width.
package cpu_run_pkg;

  localparam int CNT_W = 32;

  localparam logic [1:0] TAG_REG   = 2'b00;
  localparam logic [1:0] TAG_MEM   = 2'b01;
  localparam logic [1:0] TAG_COUNT = 2'b10;

  typedef enum logic [3:0] {
    S_Idle,
    S_Reset,
    S_WaitReady,
    S_Run,
    S_RegRead,
    S_RegEmit,
    S_MemRead,
    S_MemEmit,
    S_CountEmit
  } state_e;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating 32-bit run-cycle counter with clear and enable.
// Build option CPU_RUN_WATCHDOG_EN adds the limit comparator on limit_hit_o.
module run_cycle_counter
  import cpu_run_pkg::*;
#(
  parameter int unsigned Limit = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             limit_hit_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef CPU_RUN_WATCHDOG_EN
  // Fires in the run cycle whose increment brings the count up to Limit.
  assign limit_hit_o = en_i && (count_q == CNT_W'(Limit - 1));
`else
  logic unused_limit;
  assign unused_limit = ^CNT_W'(Limit);
  assign limit_hit_o  = 1'b0;
`endif

endmodule

// File: rtl/cpu_run_monitor.sv
// A09 run controller: pulses CPU reset, times the run, then dumps registers, memory and cycle count.
// Build option CPU_RUN_WATCHDOG_EN ends a run that reaches WatchdogLimit cycles and flags Timeout.
module cpu_run_monitor
  import cpu_run_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int AddrWidth     = 8,
  parameter int RegCount      = 8,
  parameter int DumpDepth     = 15,
  parameter int ResetCycles   = 2,
  parameter int WatchdogLimit = 10000
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  output logic                        CpuReset_n,
  input  logic                        CpuReady,
  input  logic                        CpuHalt,
  output logic [$clog2(RegCount)-1:0] RegAddr,
  input  logic [DataWidth-1:0]        RegData,
  output logic [AddrWidth-1:0]        MemAddr,
  input  logic [DataWidth-1:0]        MemData,
  output logic [DataWidth-1:0]        DumpData,
  output logic [1:0]                  DumpTag,
  output logic [AddrWidth-1:0]        DumpIndex,
  output logic                        DumpValid,
  input  logic                        DumpReady,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Timeout,
  output logic [CNT_W-1:0]            CycleCount
);

  localparam int RegAW   = $clog2(RegCount);
  localparam int RstCntW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
  localparam logic [RstCntW-1:0]   LastRst = RstCntW'(ResetCycles - 1);
  localparam logic [AddrWidth-1:0] LastReg = AddrWidth'(RegCount - 1);
  localparam logic [AddrWidth-1:0] LastMem = AddrWidth'(DumpDepth - 1);

  state_e                 state_q, state_d;
  logic [RstCntW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [RegAW-1:0]       reg_addr_q, reg_addr_d;
  logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [AddrWidth-1:0]   index_q, index_d;
  logic [1:0]             tag_q, tag_d;
  logic [DataWidth-1:0]   data_q, data_d, raw_data;
  logic                   held_q, held_d;
  logic                   done_q, done_d;
  logic                   halt_prev_q;
  logic                   run_start, emit, xfer, halt_fall, limit_hit;
  logic [CNT_W-1:0]       cycle_count;

  run_cycle_counter #(
    .Limit (WatchdogLimit)
  ) u_cycle_counter (
    .clk         (Clk),
    .rst_n       (Reset),
    .clr_i       (run_start),
    .en_i        (state_q == S_Run),
    .count_o     (cycle_count),
    .limit_hit_o (limit_hit)
  );

  always_comb begin
    run_start  = (state_q == S_Idle) && Start;
    emit       = state_q inside {S_RegEmit, S_MemEmit, S_CountEmit};
    xfer       = emit && DumpReady;
    halt_fall  = halt_prev_q && !CpuHalt;

    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    index_d    = index_q;
    tag_d      = tag_q;
    done_d     = done_q;

    unique case (state_q)
      S_Idle: if (Start) begin
        state_d   = S_Reset;
        rst_cnt_d = '0;
        done_d    = 1'b0;
      end
      S_Reset: begin
        if (rst_cnt_q == LastRst) state_d = S_WaitReady;
        else                      rst_cnt_d = rst_cnt_q + RstCntW'(1);
      end
      S_WaitReady: if (CpuReady) state_d = S_Run;
      S_Run: if (halt_fall || limit_hit) begin
        state_d    = S_RegRead;
        reg_addr_d = '0;
        tag_d      = TAG_REG;
        index_d    = '0;
      end
      S_RegRead: state_d = S_RegEmit;
      S_RegEmit: if (xfer) begin
        if (index_q == LastReg) begin
          state_d    = S_MemRead;
          mem_addr_d = '0;
          tag_d      = TAG_MEM;
          index_d    = '0;
        end else begin
          state_d    = S_RegRead;
          reg_addr_d = reg_addr_q + RegAW'(1);
          index_d    = index_q + AddrWidth'(1);
        end
      end
      S_MemRead: state_d = S_MemEmit;
      S_MemEmit: if (xfer) begin
        if (index_q == LastMem) begin
          state_d = S_CountEmit;
          tag_d   = TAG_COUNT;
          index_d = '0;
        end else begin
          state_d    = S_MemRead;
          mem_addr_d = mem_addr_q + AddrWidth'(1);
          index_d    = index_q + AddrWidth'(1);
        end
      end
      S_CountEmit: if (xfer) begin
        state_d = S_Idle;
        done_d  = 1'b1;
      end
      default: state_d = S_Idle;
    endcase

    unique case (state_q)
      S_RegEmit: raw_data = RegData;
      S_MemEmit: raw_data = MemData;
      default:   raw_data = cycle_count[DataWidth-1:0];
    endcase

    // Read data arrives in the first emit cycle; it is passed straight through then and held from the
    // captured copy while the consumer stalls, so the word stays stable even if the source changes.
    held_d = emit && !DumpReady;
    data_d = (emit && !held_q) ? raw_data : data_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_Idle;
      rst_cnt_q   <= '0;
      reg_addr_q  <= '0;
      mem_addr_q  <= '0;
      index_q     <= '0;
      tag_q       <= TAG_REG;
      data_q      <= '0;
      held_q      <= 1'b0;
      done_q      <= 1'b0;
      halt_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      reg_addr_q  <= reg_addr_d;
      mem_addr_q  <= mem_addr_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      held_q      <= held_d;
      done_q      <= done_d;
      halt_prev_q <= CpuHalt;
    end
  end

`ifdef CPU_RUN_WATCHDOG_EN
  logic timeout_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      timeout_q <= 1'b0;
    end else if (run_start) begin
      timeout_q <= 1'b0;
    end else if (limit_hit && !halt_fall) begin
      timeout_q <= 1'b1;
    end
  end

  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  assign CpuReset_n = !(state_q inside {S_Idle, S_Reset});
  assign Busy       = (state_q != S_Idle);
  assign DumpValid  = emit;
  assign DumpData   = (emit && !held_q) ? raw_data : data_q;
  assign DumpTag    = tag_q;
  assign DumpIndex  = index_q;
  assign RegAddr    = reg_addr_q;
  assign MemAddr    = mem_addr_q;
  assign Done       = done_q;
  assign CycleCount = cycle_count;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: CPU boot/halt stimulus, register/memory models and a dump consumer.
module tb_cpu_run_monitor;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        CpuReady = 1'b0;
  logic        CpuHalt = 1'b0;
  logic        DumpReady = 1'b0;
  logic        CpuReset_n, DumpValid, Busy, Done, Timeout;
  logic [2:0]  RegAddr;
  logic [7:0]  MemAddr, DumpIndex;
  logic [15:0] RegData, MemData, DumpData;
  logic [1:0]  DumpTag;
  logic [31:0] CycleCount;

  int n_vec  = 0;
  int n_miss = 0;
  int nw, nb;

  cpu_run_monitor #(
    .DataWidth(16), .AddrWidth(8), .RegCount(8), .DumpDepth(15), .ResetCycles(2), .WatchdogLimit(100)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .CpuReset_n(CpuReset_n), .CpuReady(CpuReady),
    .CpuHalt(CpuHalt), .RegAddr(RegAddr), .RegData(RegData), .MemAddr(MemAddr), .MemData(MemData),
    .DumpData(DumpData), .DumpTag(DumpTag), .DumpIndex(DumpIndex), .DumpValid(DumpValid),
    .DumpReady(DumpReady), .Busy(Busy), .Done(Done), .Timeout(Timeout), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  // Register file and memory with one-cycle read latency.
  always @(posedge Clk) begin
    RegData <= 16'h1000 + {13'd0, RegAddr};
    MemData <= 16'hA000 + {8'd0, MemAddr};
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {valid, tag, index, data} of the n-th dump word.
  function automatic logic [26:0] exp_word(input int n, input logic [15:0] cnt);
    if (n < 8)       return {1'b1, 2'b00, 8'(n), 16'h1000 + 16'(n)};
    else if (n < 23) return {1'b1, 2'b01, 8'(n - 8), 16'hA000 + 16'(n - 8)};
    else             return {1'b1, 2'b10, 8'h00, cnt};
  endfunction

  // Start a run and bring the CPU out of reset; returns in the first S_Run cycle.
  task automatic boot(input logic halt_init);
    CpuReady  = 1'b0;
    CpuHalt   = halt_init;
    DumpReady = 1'b0;
    Start     = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("boot_rstn_lo0", CpuReset_n, 0);
    check("boot_busy", Busy, 1);
    check("boot_done_clr", Done, 0);
    check("boot_cnt_clr", CycleCount, 0);
    check("boot_timeout_clr", Timeout, 0);
    @(negedge Clk);
    check("boot_rstn_lo1", CpuReset_n, 0);
    @(negedge Clk);
    check("boot_rstn_rise", CpuReset_n, 1);
    repeat (3) @(negedge Clk);
    check("wait_no_valid", DumpValid, 0);
    CpuReady = 1'b1;
    @(negedge Clk);
  endtask

  // Drive CpuHalt per run cycle (1-based); halt is high for cycles hi_from..hi_to.
  task automatic run_cpu(input int n, input int hi_from, input int hi_to, input int start_at);
    for (int k = 1; k <= n; k++) begin
      CpuHalt = (k >= hi_from) && (k <= hi_to);
      Start   = (k == start_at);
      @(negedge Clk);
    end
    Start   = 1'b0;
    CpuHalt = 1'b0;
  endtask

  // Consume the dump. toggle=1 holds DumpReady low on odd cycles. abort_word>=0 returns while that
  // word is presented, without accepting it.
  task automatic collect(input bit toggle, input logic [15:0] cnt, input int abort_word,
                         input int start_at, output int n_words, output int n_busy);
    logic [26:0] fields, prev_fields;
    logic        prev_stall;
    bit          stop;
    prev_stall  = 1'b0;
    prev_fields = '0;
    stop        = 1'b0;
    n_words     = 0;
    n_busy      = 0;
    while ((Busy === 1'b1) && (n_busy < 400) && !stop) begin
      if ((abort_word >= 0) && (n_words == abort_word) && (DumpValid === 1'b1)) begin
        DumpReady = 1'b0;
        stop      = 1'b1;
      end else begin
        DumpReady = toggle ? (n_busy % 2 == 0) : 1'b1;
        Start     = (n_busy == start_at);
        fields    = {DumpValid, DumpTag, DumpIndex, DumpData};
        if (prev_stall) check($sformatf("stall_hold_w%0d", n_words), 32'(fields), 32'(prev_fields));
        if (DumpValid && DumpReady) begin
          check($sformatf("word_%0d", n_words), 32'(fields), 32'(exp_word(n_words, cnt)));
          n_words++;
        end
        prev_stall  = DumpValid && !DumpReady;
        prev_fields = fields;
        n_busy++;
        @(negedge Clk);
      end
    end
    Start = 1'b0;
    if (!stop) check("dump_terminates", Busy, 0);
  endtask

  initial begin
    // Power-on reset values.
    repeat (2) @(negedge Clk);
    check("rst_cpu_reset_n", CpuReset_n, 0);
    check("rst_regaddr", RegAddr, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_dumpdata", DumpData, 0);
    check("rst_dumptag", DumpTag, 0);
    check("rst_dumpindex", DumpIndex, 0);
    check("rst_dumpvalid", DumpValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_count", CycleCount, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Halt high for run cycles 20-24, falls at 25; full-rate dump.
    boot(1'b0);
    run_cpu(25, 20, 24, -1);
    check("t1_count", CycleCount, 25);
    collect(1'b0, 16'h0019, -1, -1, nw, nb);
    check("t1_words", nw, 24);
    check("t1_dump_cycles", nb, 47);
    check("t1_done", Done, 1);
    check("t1_busy", Busy, 0);
    check("t1_cpu_reset", CpuReset_n, 0);
    check("t1_timeout", Timeout, 0);

    // Backpressure on every other cycle.
    boot(1'b0);
    run_cpu(10, 5, 9, -1);
    check("t2_count", CycleCount, 10);
    collect(1'b1, 16'h000A, -1, -1, nw, nb);
    check("t2_words", nw, 24);
    check("t2_done", Done, 1);

    // Start pulses in S_Run and on a dump transfer cycle are ignored.
    boot(1'b0);
    run_cpu(12, 3, 11, 6);
    check("t3_count_run", CycleCount, 12);
    collect(1'b1, 16'h000C, -1, 4, nw, nb);
    check("t3_words", nw, 24);
    check("t3_count_kept", CycleCount, 12);
    check("t3_done", Done, 1);

    // Halt already high on entry to S_Run, falls in run cycle 7.
    boot(1'b1);
    run_cpu(7, 1, 6, -1);
    check("t4_count", CycleCount, 7);
    collect(1'b0, 16'h0007, -1, -1, nw, nb);
    check("t4_words", nw, 24);

`ifdef CPU_RUN_WATCHDOG_EN
    // Halt never falls; watchdog ends the run at 100 cycles.
    boot(1'b0);
    run_cpu(100, 1000, 1000, -1);
    check("t5_count", CycleCount, 100);
    check("t5_timeout", Timeout, 1);
    collect(1'b0, 16'h0064, -1, -1, nw, nb);
    check("t5_words", nw, 24);
    check("t5_dump_cycles", nb, 47);
    check("t5_done", Done, 1);
    check("t5_timeout_sticky", Timeout, 1);
`else
    // Without the watchdog the run waits past any limit until halt falls.
    boot(1'b0);
    run_cpu(150, 1000, 1000, -1);
    check("t5_still_busy", Busy, 1);
    check("t5_no_valid", DumpValid, 0);
    check("t5_count_mid", CycleCount, 150);
    check("t5_timeout", Timeout, 0);
    run_cpu(2, 1, 1, -1);
    check("t5_count", CycleCount, 152);
    collect(1'b0, 16'h0098, -1, -1, nw, nb);
    check("t5_words", nw, 24);
    check("t5_done", Done, 1);
`endif

    // Reset while memory word 5 is presented, then a clean run.
    boot(1'b0);
    run_cpu(4, 2, 3, -1);
    collect(1'b0, 16'h0004, 13, -1, nw, nb);
    check("t6_pre_tag", DumpTag, 2'b01);
    check("t6_pre_index", DumpIndex, 5);
    check("t6_pre_valid", DumpValid, 1);
    Reset = 1'b0;
    #1;
    check("t6_valid_drop", DumpValid, 0);
    check("t6_cpu_reset", CpuReset_n, 0);
    check("t6_busy", Busy, 0);
    check("t6_data", DumpData, 0);
    check("t6_index", DumpIndex, 0);
    check("t6_tag", DumpTag, 0);
    check("t6_memaddr", MemAddr, 0);
    check("t6_count", CycleCount, 0);
    check("t6_done", Done, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("t6_idle_valid", DumpValid, 0);
    boot(1'b0);
    run_cpu(5, 1, 4, -1);
    check("t6_new_count", CycleCount, 5);
    collect(1'b0, 16'h0005, -1, -1, nw, nb);
    check("t6_new_words", nw, 24);
    check("t6_new_cycles", nb, 47);
    check("t6_new_done", Done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and state dumper for the A09 CPU. It drives the CPU reset pulse, waits for Ready, counts execution cycles and detects the end of a run on the falling edge of halt. It then streams the register file, a memory window and the cycle count out over a valid/ready port. It sits beside the CPU in FPGA builds and replaces the testbench-only reset/halt/dump sequencing.

## Interface
Parameters:
- DataWidth, 16, width of register, memory and dump words
- AddrWidth, 8, memory address width; also the width of DumpIndex
- RegCount, 8, number of register-file entries dumped (power of two, ≥2)
- DumpDepth, 15, memory words dumped, from address 0 to DumpDepth-1 (1..2^AddrWidth)
- ResetCycles, 2, number of cycles CpuReset_n is held low after Start (≥1)
- WatchdogLimit, 10000, run-cycle limit; used only with CPU_RUN_WATCHDOG_EN

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low
- Start  in  1  single-cycle request to begin a run; ignored while Busy
- CpuReset_n  out  1  CPU reset, active-low
- CpuReady  in  1  CPU finished its own reset sequence
- CpuHalt  in  1  CPU halt indicator
- RegAddr  out  $clog2(RegCount)  register-file read address
- RegData  in  DataWidth  register read data, 1-cycle latency
- MemAddr  out  AddrWidth  memory read address
- MemData  in  DataWidth  memory read data, 1-cycle latency
- DumpData  out  DataWidth  dump word
- DumpTag  out  2  dump word type: 00 register, 01 memory, 10 cycle count
- DumpIndex  out  AddrWidth  register or memory index; 0 for the count word
- DumpValid  out  1  dump word valid
- DumpReady  in  1  downstream consumer accepts the dump word
- Busy  out  1  run or dump in progress
- Done  out  1  sticky; last run finished; cleared by Start
- Timeout  out  1  sticky; last run was ended by the watchdog
- CycleCount  out  32  cycles spent in S_Run; saturates at 0xFFFF_FFFF

## Operation
- States:
  - S_Idle → S_Reset on Start.
  - S_Reset → S_WaitReady after ResetCycles cycles.
  - S_WaitReady → S_Run when CpuReady=1.
  - S_Run → S_RegRead on the halt fall or on a watchdog hit.
  - S_RegRead ↔ S_RegEmit until all RegCount entries are sent.
  - S_MemRead ↔ S_MemEmit until all DumpDepth words are sent.
  - S_CountEmit → S_Idle.
- CpuReset_n is 0 in S_Idle and S_Reset and 1 in all other states. Returning to S_Idle re-asserts CPU reset.
- Halt fall detection: a registered copy of CpuHalt; the fall is prev=1 and now=0. A halt that is still high when the state leaves S_Run is not a fall.
- CycleCount: cleared on Start; increments each cycle in S_Run, including the cycle in which the fall is detected; saturating.
- Dump order:
  - registers 0..RegCount-1 (tag 00)
  - memory 0..DumpDepth-1 (tag 01)
  - one count word, CycleCount[DataWidth-1:0] (tag 10)
- Read states drive RegAddr or MemAddr. The following Emit state captures the data into DumpData and raises DumpValid.
- Handshake:
  - A word transfers on a cycle where DumpValid=1 and DumpReady=1.
  - DumpData, DumpTag and DumpIndex must stay stable while DumpValid=1 and DumpReady=0.
  - DumpValid never drops without a transfer.
- Busy=1 in every state except S_Idle.
- Done is set on the count-word transfer.
- A Start pulse arriving during Busy is ignored.

## Timing
- Reset values: state S_Idle, CpuReset_n=0, RegAddr=0, MemAddr=0, DumpData=0, DumpTag=0, DumpIndex=0, DumpValid=0, Busy=0, Done=0, Timeout=0, CycleCount=0.
- Start sampled at cycle T: S_Reset at T+1; CpuReset_n rises at T+1+ResetCycles.
- Per dump word: 2 cycles minimum (read + emit with DumpReady=1). The full dump takes 2·(RegCount+DumpDepth)+1 cycles with zero backpressure.
- Done and Busy=0 one cycle after the final transfer.
- Asserting Reset mid-run or mid-dump drops DumpValid immediately (asynchronously) and asserts CpuReset_n=0. No partial dump resumes.
- Asserting Start in the same cycle as a transfer has no effect while Busy.

## Configuration
- CPU_RUN_WATCHDOG_EN defined: when CycleCount reaches WatchdogLimit in S_Run without a halt fall:
  - Timeout is set
  - the state moves to S_RegRead, and the dump proceeds normally
  - the count word equals WatchdogLimit
- CPU_RUN_WATCHDOG_EN undefined: no comparator is built, Timeout is tied to 0, and S_Run waits indefinitely.

## Structure
- A shared package cpu_run_pkg holds:
  - the state enum
  - the DumpTag constants TAG_REG=2'b00, TAG_MEM=2'b01, TAG_COUNT=2'b10
  - the 32-bit counter width constant
- One sub-module: run_cycle_counter. It is a saturating 32-bit counter with clear, enable, and an optional limit-compare output under CPU_RUN_WATCHDOG_EN.
- All other logic (FSM, dump index counter, output registers) stays in cpu_run_monitor.

## Test plan
- Start; CpuReady high 3 cycles after CpuReset_n rises; CpuHalt high for cycles 20–24 of S_Run, then low → CycleCount=25 and 24 dump words (8 reg, 15 mem, count=0x0019) in order; Done=1, Busy=0.
- RegData=0x1000+index, MemData=0xA000+addr, DumpReady toggled every other cycle → words match, fields stable while stalled, no duplicates or drops.
- Reset asserted during memory word 5 → all outputs at reset values; a new Start gives a full clean run.
- Start pulsed during S_Run and during the dump → ignored; CycleCount is not cleared.
- CPU_RUN_WATCHDOG_EN with WatchdogLimit=100 and CpuHalt held 0 → Timeout=1, count word=0x0064, full dump follows.
- CpuHalt already high on entry to S_Run, falling after 7 cycles → fall detected, CycleCount=7.
